// File: rtl/double_tokens.sv
// double_tokens: serial token expander. Every accepted '1' on a becomes two
// '1' tokens on b, emitted at most one per cycle from a bounded backlog.
//
// Ports:
//   clk       clock, all state updates on posedge
//   rst       synchronous active-high reset; clears backlog and overflow
//   a         incoming token (one token offered per cycle when high)
//   a_ready   high when an incoming token can be accepted this cycle
//   b         outgoing token, high whenever the backlog is non-zero
//   b_ready   downstream accepts the token on b this cycle
//   pending   current backlog count
//   overflow  sticky: a token arrived while a_ready was low
//
// a_ready and b are decoded from the registered count only, so there is no
// combinational path from a or b_ready to any output.
module double_tokens #(
  parameter int unsigned  MAX_PENDING = 8,
  localparam int unsigned CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  output logic             a_ready,
  output logic             b,
  input  logic             b_ready,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  // Highest count that still leaves room for the two tokens of one accept.
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(MAX_PENDING - 2);

  logic [CNT_W-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic             acc, emt, drop;

  // Handshake decode and next-state for the backlog counter and sticky flag.
  always_comb begin
    a_ready    = (pending_q <= READY_MAX);
    b          = (pending_q != '0);
    acc        = a & a_ready;
    emt        = b & b_ready;
    drop       = a & ~a_ready;
    pending_d  = pending_q;
    overflow_d = overflow_q | drop;
    // Accept and emit together net +1; a_ready and b rule out wrap.
    if (acc) pending_d = pending_d + CNT_W'(2);
    if (emt) pending_d = pending_d - CNT_W'(1);
  end

  // State registers; reset wins over any same-cycle accept or emit.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule
